// File: rtl/cve2_pkg.sv
// cve2_pkg: shared types for the CVE2 core clock-gate controller.
package cve2_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_IDLE  = 2'd1,
        CG_SLEEP = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    // Delay counter must hold the larger of the two delays; never narrower than 1 bit.
    function automatic int cg_cnt_width(input int idle_delay, input int wake_delay);
        int m;
        m = (idle_delay > wake_delay) ? idle_delay : wake_delay;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cve2_sleep_ctrl.sv
// cve2_sleep_ctrl: registered core clock-gate controller with idle hysteresis,
// maskable and unmaskable wake sources, wake settle delay and sleep statistics.
module cve2_sleep_ctrl
    import cve2_pkg::*;
#(
    parameter int NumWakeSrc    = 4,
    parameter int IdleDelay     = 2,
    parameter int WakeDelay     = 1,
    parameter int SleepCntWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     core_busy_i,
    input  logic [NumWakeSrc-1:0]    wake_i,
    input  logic [NumWakeSrc-1:0]    wake_mask_i,
    input  logic                     wake_nm_i,
    input  logic                     test_en_i,
    output logic                     clock_en_o,
    output logic                     core_sleep_o,
    output logic [NumWakeSrc:0]      wake_cause_o,
    output logic [SleepCntWidth-1:0] sleep_cnt_o
);

    localparam int CntW = cg_cnt_width(IdleDelay, WakeDelay);
    localparam logic [CntW-1:0] IdleLoad = CntW'((IdleDelay > 0) ? IdleDelay - 1 : 0);
    localparam logic [CntW-1:0] WakeLoad = CntW'((WakeDelay > 0) ? WakeDelay - 1 : 0);

    cg_state_e                state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     en_q, sleep_q, capture, enter_sleep, wake_any, stay;
    logic [NumWakeSrc:0]      cause_q;
    logic [SleepCntWidth-1:0] sleep_cnt_q;

    assign wake_any    = wake_nm_i | |(wake_i & wake_mask_i);
    assign stay        = core_busy_i | wake_any;
    assign enter_sleep = (state_d == CG_SLEEP) && (state_q != CG_SLEEP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            CG_RUN: if (!stay) begin
                state_d = (IdleDelay > 0) ? CG_IDLE : CG_SLEEP;
                cnt_d   = IdleLoad;
            end
            CG_IDLE: if (stay) state_d = CG_RUN;
                else if (cnt_q == '0) state_d = CG_SLEEP;
                else cnt_d = cnt_q - 1'b1;
            // A busy core cannot wake itself here: its clock is already gated.
            CG_SLEEP: if (wake_any) begin
                capture = 1'b1;
                state_d = (WakeDelay > 0) ? CG_WAKE : CG_RUN;
                cnt_d   = WakeLoad;
            end
            CG_WAKE: if (cnt_q == '0) state_d = CG_RUN;
                else cnt_d = cnt_q - 1'b1;
            default: state_d = CG_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CG_RUN;
            cnt_q       <= '0;
            en_q        <= 1'b1;
            sleep_q     <= 1'b0;
            cause_q     <= '0;
            sleep_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d == CG_RUN) || (state_d == CG_IDLE);
            sleep_q <= (state_d == CG_SLEEP) || (state_d == CG_WAKE);
            if (capture) cause_q <= {wake_nm_i, wake_i & wake_mask_i};
            if (enter_sleep && !(&sleep_cnt_q)) sleep_cnt_q <= sleep_cnt_q + 1'b1;
        end
    end

    assign clock_en_o   = en_q | test_en_i;
    assign core_sleep_o = sleep_q;
    assign wake_cause_o = cause_q;
    assign sleep_cnt_o  = sleep_cnt_q;

    a_clock_en_known: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(clock_en_o));
    a_no_sleep_busy:  assert property (@(posedge clk_i) disable iff (rst_i) enter_sleep |-> !core_busy_i);

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// tb_cve2_sleep_ctrl: table-driven bench for the clock-gate controller plus
// hand sequences for reset-in-flight, counter saturation and zero delays.
module tb_cve2_sleep_ctrl;

    typedef struct {
        logic        busy;
        logic [3:0]  wake;
        logic [3:0]  mask;
        logic        nm;
        logic        ten;
        logic        en;
        logic        sl;
        logic [4:0]  cause;
        logic [15:0] cnt;
    } vec_t;

    logic        clk, rst, busy, nm, ten;
    logic [3:0]  wake, mask;
    logic        en, sl, en2, sl2;
    logic [4:0]  cause, cause2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    int          checks = 0;
    int          failures = 0;
    vec_t        tbl[26];

    cve2_sleep_ctrl dut (
        .clk_i(clk), .rst_i(rst), .core_busy_i(busy), .wake_i(wake), .wake_mask_i(mask),
        .wake_nm_i(nm), .test_en_i(ten), .clock_en_o(en), .core_sleep_o(sl),
        .wake_cause_o(cause), .sleep_cnt_o(cnt)
    );

    cve2_sleep_ctrl #(.IdleDelay(0), .WakeDelay(0), .SleepCntWidth(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .core_busy_i(busy), .wake_i(wake), .wake_mask_i(mask),
        .wake_nm_i(nm), .test_en_i(ten), .clock_en_o(en2), .core_sleep_o(sl2),
        .wake_cause_o(cause2), .sleep_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic b, logic [3:0] w, logic [3:0] m, logic n, logic t,
                                logic e, logic s, logic [4:0] c, logic [15:0] k);
        vec_t v;
        v.busy = b; v.wake = w; v.mask = m; v.nm = n; v.ten = t;
        v.en = e; v.sl = s; v.cause = c; v.cnt = k;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic [3:0] w, input logic [3:0] m, input logic n, input logic t);
        busy = b; wake = w; mask = m; nm = n; ten = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        // IdleDelay=2, WakeDelay=1 expectations, one row per clock.
        tbl[0]  = mk(1, 4'h0, 4'h0, 0, 0, 1, 0, 5'h00, 0);
        tbl[1]  = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h00, 0);
        tbl[2]  = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h00, 0);
        tbl[3]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 5'h00, 1);
        tbl[4]  = mk(0, 4'h1, 4'h2, 0, 0, 0, 1, 5'h00, 1);
        tbl[5]  = mk(0, 4'h0, 4'h2, 0, 0, 0, 1, 5'h00, 1);
        tbl[6]  = mk(0, 4'h2, 4'h2, 0, 0, 0, 1, 5'h02, 1);
        tbl[7]  = mk(1, 4'h2, 4'h2, 0, 0, 1, 0, 5'h02, 1);
        tbl[8]  = mk(1, 4'h0, 4'h0, 0, 0, 1, 0, 5'h02, 1);
        tbl[9]  = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h02, 1);
        tbl[10] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h02, 1);
        tbl[11] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 5'h02, 2);
        tbl[12] = mk(1, 4'h0, 4'h0, 0, 1, 1, 1, 5'h02, 2);
        tbl[13] = mk(0, 4'hf, 4'h0, 1, 0, 0, 1, 5'h10, 2);
        tbl[14] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h10, 2);
        tbl[15] = mk(1, 4'h0, 4'h0, 0, 0, 1, 0, 5'h10, 2);
        tbl[16] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h10, 2);
        tbl[17] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h10, 2);
        tbl[18] = mk(0, 4'h4, 4'h4, 0, 0, 1, 0, 5'h10, 2);
        tbl[19] = mk(0, 4'h0, 4'h0, 1, 0, 1, 0, 5'h10, 2);
        tbl[20] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h10, 2);
        tbl[21] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h10, 2);
        tbl[22] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 5'h10, 3);
        tbl[23] = mk(0, 4'h8, 4'h8, 1, 0, 0, 1, 5'h18, 3);
        tbl[24] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 5'h18, 3);
        tbl[25] = mk(1, 4'h0, 4'h0, 0, 0, 1, 0, 5'h18, 3);

        rst = 1'b1;
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_en", 0, 32'(en), 32'd1);
        chk("reset_sleep", 0, 32'(sl), 32'd0);
        chk("reset_cause", 0, 32'(cause), 32'd0);
        chk("reset_cnt", 0, 32'(cnt), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].busy, tbl[i].wake, tbl[i].mask, tbl[i].nm, tbl[i].ten);
            step();
            chk("tbl_en", i, 32'(en), 32'(tbl[i].en));
            chk("tbl_sleep", i, 32'(sl), 32'(tbl[i].sl));
            chk("tbl_cause", i, 32'(cause), 32'(tbl[i].cause));
            chk("tbl_cnt", i, 32'(cnt), 32'(tbl[i].cnt));
        end

        // Asynchronous reset while IDLE.
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        step();
        chk("pre_rst_idle_en", 0, 32'(en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_idle_en", 0, 32'(en), 32'd1);
        chk("rst_idle_sleep", 0, 32'(sl), 32'd0);
        chk("rst_idle_cnt", 0, 32'(cnt), 32'd0);
        chk("rst_idle_cause", 0, 32'(cause), 32'd0);
        do_reset();

        // Zero delays and 2-bit saturating sleep counter on dut2.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
            step();
            chk("z_sleep_en", i, 32'(en2), 32'd0);
            chk("z_sleep_sl", i, 32'(sl2), 32'd1);
            drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
            step();
            chk("z_wake_en", i, 32'(en2), 32'd1);
        end
        chk("sat_cnt", 0, 32'(cnt2), 32'd3);
        chk("z_cause", 0, 32'(cause2), 32'h10);
        drive(1'b0, 4'hf, 4'h0, 1'b0, 1'b0);
        repeat (10) step();
        chk("masked_asleep_en", 0, 32'(en2), 32'd0);
        chk("masked_asleep_sl", 0, 32'(sl2), 32'd1);
        chk("masked_asleep_cnt", 0, 32'(cnt2), 32'd3);
        ten = 1'b1;
        #1;
        chk("test_en_comb", 0, 32'(en2), 32'd1);
        chk("test_en_sl", 0, 32'(sl2), 32'd1);
        step();
        chk("test_en_hold", 0, 32'(en2), 32'd1);
        ten = 1'b0;
        #1;
        chk("test_en_off", 0, 32'(en2), 32'd0);

        // Asynchronous reset while WAKE on the main instance.
        do_reset();
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) step();
        chk("pre_wake_sleep", 0, 32'(sl), 32'd1);
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        step();
        chk("in_wake_en", 0, 32'(en), 32'd0);
        chk("in_wake_cause", 0, 32'(cause), 32'h10);
        #2 rst = 1'b1;
        #1;
        chk("rst_wake_en", 0, 32'(en), 32'd1);
        chk("rst_wake_sleep", 0, 32'(sl), 32'd0);
        chk("rst_wake_cause", 0, 32'(cause), 32'd0);
        chk("rst_wake_cnt", 0, 32'(cnt), 32'd0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
